vx_interrupt_controller: RTL and testbench
==========================================

// Module: VX_interrupt_controller
// PURPOSE
//  IRQC: front end for thread transfer. Accepts a transfer request (wid, tid, ISR PC) from the scalar core (SC).
//  Drives the IRQC state and load data to the thread transfer unit (TTU) in the SIMT scheduler over VX_interrupt_ctl_ttu_if.
//  Snapshots the warp context and returns a completion response to the SC.
//  Sits between the SC request port and the TTU; one transfer in flight at a time.
// PARAMETERS
//  THREAD_CNT      `NUM_THREADS           threads per warp
//  WARP_CNT        `NUM_WARPS             warps per core
//  WARP_CNT_WIDTH  `LOG2UP(WARP_CNT)      warp id width
//  TID_WIDTH       `LOG2UP(THREAD_CNT)    thread id width
//  TIMEOUT_CYCLES  1024                   max cycles in IRQC_WAIT (only with IRQC_TIMEOUT_EN)
// PORTS
//  clk                   in   1               clock
//  reset                 in   1               sync active-high reset
//  irq_valid             in   1               SC transfer request valid
//  irq_ready             out  1               request accepted when valid&&ready
//  irq_wid               in   WARP_CNT_WIDTH  target warp
//  irq_tid               in   TID_WIDTH       target thread
//  irq_isr_pc            in   XLEN            ISR entry PC
//  rha_addr              in   XLEN            return-handler address; quasi-static
//  resp_valid            out  1               completion valid, held until resp_ready
//  resp_ready            in   1               SC accepts response
//  resp_status           out  2               0 OK, 1 NOT_FOUND, 2 TIMEOUT, 3 BAD_ARG
//  resp_pc               out  XLEN            saved warp PC (OK), else 0
//  interrupt_ctl_ttu_if  master  -            drives state, wid, tid, load_PC, load_tmask, load_wmask, RHA
//                                              samples pipeline_drained, thread_found, current_thread_mask,
//                                              current_PC, current_active_warps, ISR_done
// BEHAVIOUR
//  Reset
//   - state=IRQC_IDLE; latched wid, tid, isr_pc and saved masks/PC = 0.
//   - resp_valid=0, resp_status=0, resp_pc=0, load_* = 0.
//   - irq_ready=1 from first cycle after reset.
//   - Reset mid-transfer abandons it silently; no response.
//  Interface outputs
//   - irq_ready = (state==IRQC_IDLE) && !resp_valid (combinational).
//   - ttu.RHA = rha_addr.
//   - ttu.state, wid and tid come from registers.
//  FSM (one transition per cycle max)
//   - IRQC_IDLE: on request accept, latch wid/tid/isr_pc.
//     - irq_tid>=THREAD_CNT or irq_wid>=WARP_CNT: stay IDLE, resp_valid=1 status BAD_ARG next cycle.
//     - Otherwise go to IRQC_WAIT.
//   - IRQC_WAIT: while pipeline_drained=0, stay in WAIT.
//     - pipeline_drained && thread_found: save current_PC, current_thread_mask, current_active_warps;
//       go to IRQC_PC_SWAP.
//     - pipeline_drained && !thread_found: go to IDLE, respond NOT_FOUND.
//   - IRQC_PC_SWAP: exactly 1 cycle; load_PC=isr_pc; go to IRQC_WAIT_ISR.
//   - IRQC_WAIT_ISR: load_PC held = isr_pc (TTU matches the ISR-end jump against it); on ISR_done go to IRQC_REVERT_WARP.
//   - IRQC_REVERT_WARP: exactly 1 cycle; load_PC=saved PC, load_tmask=saved tmask, load_wmask=saved active warps.
//     Next cycle: IDLE, resp_valid=1, status OK, resp_pc=saved PC.
//  Response
//   - resp_valid, resp_status and resp_pc are registered and stay stable until resp_valid&&resp_ready.
//   - A new request is blocked while a response is pending.
//  Misc
//   - load_* = 0 in IRQC_IDLE and IRQC_WAIT.
//   - irq_* inputs are ignored outside the accept handshake.
// CONFIGURATION
//  IRQC_TIMEOUT_EN defined:
//   - 16-bit counter cleared on entry to IRQC_WAIT, increments each WAIT cycle.
//   - If it reaches TIMEOUT_CYCLES before exit: go to IDLE, respond TIMEOUT. A drain on the same cycle wins.
//  IRQC_TIMEOUT_EN undefined:
//   - No counter; WAIT waits indefinitely; status TIMEOUT is never produced.
// TESTING
//  1. Nominal transfer:
//     - Stimulus: req wid=1 tid=3 isr=0x8000_0100; drained+found 5 cycles later with current_PC=0x8000_0040,
//       tmask=0xF, active=0x3; ISR_done after 20 cycles.
//     - Response: states IDLE->WAIT->PC_SWAP->WAIT_ISR->REVERT_WARP->IDLE; REVERT load_PC=0x8000_0040,
//       load_tmask=0xF, load_wmask=0x3; status OK, resp_pc=0x8000_0040.
//  2. Thread not found: drained=1, found=0 -> IDLE; status NOT_FOUND, resp_pc=0; no PC_SWAP cycle.
//  3. Bad argument: tid=THREAD_CNT -> state stays IDLE; BAD_ARG next cycle; irq_ready=0 until resp accepted.
//  4. Backpressure: resp_ready=0 for 10 cycles -> resp fields stable, irq_ready=0; one cycle after accept,
//     irq_ready=1 and a back-to-back request is accepted.
//  5. Timeout (IRQC_TIMEOUT_EN, TIMEOUT_CYCLES=8): never drained -> TIMEOUT exactly 8 WAIT cycles after entry.
//     Without the macro, still in WAIT after 1000 cycles.
//  6. Reset in IRQC_WAIT_ISR -> next cycle IDLE, resp_valid=0, load_*=0, irq_ready=1.

Source files
------------

// File: rtl/vx_interrupt_controller_if.sv
// Thread-transfer control link between the interrupt controller (master) and the
// SIMT scheduler's thread transfer unit (slave).
interface vx_interrupt_controller_if #(
   parameter int unsigned THREAD_CNT = 4,
   parameter int unsigned WARP_CNT   = 4,
   parameter int unsigned XLEN       = 32,
   localparam int unsigned WARP_CNT_WIDTH = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1,
   localparam int unsigned TID_WIDTH      = (THREAD_CNT > 1) ? $clog2(THREAD_CNT) : 1
);
   logic [2:0]                state;
   logic [WARP_CNT_WIDTH-1:0] wid;
   logic [TID_WIDTH-1:0]      tid;
   logic [XLEN-1:0]           load_pc;
   logic [THREAD_CNT-1:0]     load_tmask;
   logic [WARP_CNT-1:0]       load_wmask;
   logic [XLEN-1:0]           rha;

   logic                      pipeline_drained;
   logic                      thread_found;
   logic [THREAD_CNT-1:0]     current_thread_mask;
   logic [XLEN-1:0]           current_pc;
   logic [WARP_CNT-1:0]       current_active_warps;
   logic                      isr_done;

   modport master (
      output state, wid, tid, load_pc, load_tmask, load_wmask, rha,
      input  pipeline_drained, thread_found, current_thread_mask, current_pc,
             current_active_warps, isr_done
   );

   modport slave (
      input  state, wid, tid, load_pc, load_tmask, load_wmask, rha,
      output pipeline_drained, thread_found, current_thread_mask, current_pc,
             current_active_warps, isr_done
   );
endinterface

// File: rtl/vx_interrupt_controller.sv
// IRQC front end: takes an SC thread-transfer request, sequences the TTU through a PC swap
// and warp revert, then returns a status. Macro IRQC_TIMEOUT_EN bounds the drain wait.
module vx_interrupt_controller #(
   parameter int unsigned THREAD_CNT = 4,
   parameter int unsigned WARP_CNT   = 4,
   parameter int unsigned XLEN       = 32,
`ifdef IRQC_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYCLES = 1024,
`endif
   localparam int unsigned WARP_CNT_WIDTH = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1,
   localparam int unsigned TID_WIDTH      = (THREAD_CNT > 1) ? $clog2(THREAD_CNT) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_irq_valid,
   output logic                      o_irq_ready,
   input  logic [WARP_CNT_WIDTH-1:0] i_irq_wid,
   input  logic [TID_WIDTH-1:0]      i_irq_tid,
   input  logic [XLEN-1:0]           i_irq_isr_pc,
   input  logic [XLEN-1:0]           i_rha_addr,
   output logic                      o_resp_valid,
   input  logic                      i_resp_ready,
   output logic [1:0]                o_resp_status,
   output logic [XLEN-1:0]           o_resp_pc,
   vx_interrupt_controller_if.master io_ttu
);

   typedef enum logic [2:0] {
      IrqcIdle       = 3'd0,
      IrqcWait       = 3'd1,
      IrqcPcSwap     = 3'd2,
      IrqcWaitIsr    = 3'd3,
      IrqcRevertWarp = 3'd4
   } irqc_state_e;

   localparam logic [1:0] STATUS_OK        = 2'd0;
   localparam logic [1:0] STATUS_NOT_FOUND = 2'd1;
   localparam logic [1:0] STATUS_BAD_ARG   = 2'd3;

   // One extra bit so a count equal to 2**width still compares correctly.
   localparam logic [TID_WIDTH:0]      TID_LIMIT  = THREAD_CNT[TID_WIDTH:0];
   localparam logic [WARP_CNT_WIDTH:0] WARP_LIMIT = WARP_CNT[WARP_CNT_WIDTH:0];

`ifdef IRQC_TIMEOUT_EN
   localparam logic [1:0]  STATUS_TIMEOUT = 2'd2;
   localparam logic [15:0] TIMEOUT_LAST   = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]            r_timeout_cnt;
`endif

   irqc_state_e           r_state;
   logic [WARP_CNT_WIDTH-1:0] r_wid;
   logic [TID_WIDTH-1:0]  r_tid;
   logic [XLEN-1:0]       r_isr_pc;
   logic [XLEN-1:0]       r_saved_pc;
   logic [THREAD_CNT-1:0] r_saved_tmask;
   logic [WARP_CNT-1:0]   r_saved_wmask;
   logic [XLEN-1:0]       r_load_pc;
   logic [THREAD_CNT-1:0] r_load_tmask;
   logic [WARP_CNT-1:0]   r_load_wmask;
   logic                  r_resp_valid;
   logic [1:0]            r_resp_status;
   logic [XLEN-1:0]       r_resp_pc;

   logic w_irq_fire;
   logic w_bad_arg;

   assign o_irq_ready = (r_state == IrqcIdle) && !r_resp_valid;
   assign w_irq_fire  = i_irq_valid && o_irq_ready;
   assign w_bad_arg   = ({1'b0, i_irq_tid} >= TID_LIMIT) || ({1'b0, i_irq_wid} >= WARP_LIMIT);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= IrqcIdle;
         r_wid         <= '0;
         r_tid         <= '0;
         r_isr_pc      <= '0;
         r_saved_pc    <= '0;
         r_saved_tmask <= '0;
         r_saved_wmask <= '0;
         r_load_pc     <= '0;
         r_load_tmask  <= '0;
         r_load_wmask  <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_status <= '0;
         r_resp_pc     <= '0;
`ifdef IRQC_TIMEOUT_EN
         r_timeout_cnt <= '0;
`endif
      end else begin
         if (r_resp_valid && i_resp_ready) begin
            r_resp_valid  <= 1'b0;
            r_resp_status <= '0;
            r_resp_pc     <= '0;
         end

         unique case (r_state)
            IrqcIdle: begin
               if (w_irq_fire) begin
                  r_wid    <= i_irq_wid;
                  r_tid    <= i_irq_tid;
                  r_isr_pc <= i_irq_isr_pc;
                  if (w_bad_arg) begin
                     r_resp_valid  <= 1'b1;
                     r_resp_status <= STATUS_BAD_ARG;
                     r_resp_pc     <= '0;
                  end else begin
                     r_state <= IrqcWait;
`ifdef IRQC_TIMEOUT_EN
                     r_timeout_cnt <= '0;
`endif
                  end
               end
            end
            IrqcWait: begin
               // A drain seen on the last allowed cycle takes priority over the timeout.
               if (io_ttu.pipeline_drained) begin
                  if (io_ttu.thread_found) begin
                     r_saved_pc    <= io_ttu.current_pc;
                     r_saved_tmask <= io_ttu.current_thread_mask;
                     r_saved_wmask <= io_ttu.current_active_warps;
                     r_load_pc     <= r_isr_pc;
                     r_state       <= IrqcPcSwap;
                  end else begin
                     r_state       <= IrqcIdle;
                     r_resp_valid  <= 1'b1;
                     r_resp_status <= STATUS_NOT_FOUND;
                     r_resp_pc     <= '0;
                  end
               end
`ifdef IRQC_TIMEOUT_EN
               else if (r_timeout_cnt == TIMEOUT_LAST) begin
                  r_state       <= IrqcIdle;
                  r_resp_valid  <= 1'b1;
                  r_resp_status <= STATUS_TIMEOUT;
                  r_resp_pc     <= '0;
               end else begin
                  r_timeout_cnt <= r_timeout_cnt + 16'd1;
               end
`endif
            end
            IrqcPcSwap: begin
               r_state <= IrqcWaitIsr;
            end
            IrqcWaitIsr: begin
               // load_pc keeps the ISR PC so the TTU can match the ISR-end jump.
               if (io_ttu.isr_done) begin
                  r_load_pc    <= r_saved_pc;
                  r_load_tmask <= r_saved_tmask;
                  r_load_wmask <= r_saved_wmask;
                  r_state      <= IrqcRevertWarp;
               end
            end
            IrqcRevertWarp: begin
               r_load_pc     <= '0;
               r_load_tmask  <= '0;
               r_load_wmask  <= '0;
               r_state       <= IrqcIdle;
               r_resp_valid  <= 1'b1;
               r_resp_status <= STATUS_OK;
               r_resp_pc     <= r_saved_pc;
            end
            default: begin
               r_state <= IrqcIdle;
            end
         endcase
      end
   end

   assign io_ttu.state      = r_state;
   assign io_ttu.wid        = r_wid;
   assign io_ttu.tid        = r_tid;
   assign io_ttu.load_pc    = r_load_pc;
   assign io_ttu.load_tmask = r_load_tmask;
   assign io_ttu.load_wmask = r_load_wmask;
   assign io_ttu.rha        = i_rha_addr;

   assign o_resp_valid  = r_resp_valid;
   assign o_resp_status = r_resp_status;
   assign o_resp_pc     = r_resp_pc;

endmodule

// File: tb/tb_vx_interrupt_controller.sv
// Bench for vx_interrupt_controller: directed transfer scenarios plus random traffic,
// all checked every cycle against a behavioural model of the transfer protocol.
module tb_vx_interrupt_controller;

   localparam int THREAD_CNT     = 6;
   localparam int WARP_CNT       = 3;
   localparam int XLEN           = 32;
   localparam int TIMEOUT_CYCLES = 8;
`ifdef IRQC_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   localparam int S_IDLE = 0, S_WAIT = 1, S_PC_SWAP = 2, S_WAIT_ISR = 3, S_REVERT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        irq_valid;
   logic        irq_ready;
   logic [1:0]  irq_wid;
   logic [2:0]  irq_tid;
   logic [31:0] irq_isr_pc;
   logic [31:0] rha_addr;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_status;
   logic [31:0] resp_pc;

   int total = 0;
   int bad   = 0;

   vx_interrupt_controller_if #(
      .THREAD_CNT(THREAD_CNT),
      .WARP_CNT  (WARP_CNT),
      .XLEN      (XLEN)
   ) u_if ();

   vx_interrupt_controller #(
      .THREAD_CNT(THREAD_CNT),
      .WARP_CNT  (WARP_CNT),
`ifdef IRQC_TIMEOUT_EN
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
`endif
      .XLEN      (XLEN)
   ) u_dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_irq_valid  (irq_valid),
      .o_irq_ready  (irq_ready),
      .i_irq_wid    (irq_wid),
      .i_irq_tid    (irq_tid),
      .i_irq_isr_pc (irq_isr_pc),
      .i_rha_addr   (rha_addr),
      .o_resp_valid (resp_valid),
      .i_resp_ready (resp_ready),
      .o_resp_status(resp_status),
      .o_resp_pc    (resp_pc),
      .io_ttu       (u_if)
   );

   always #5 clk = ~clk;

   // Behavioural model of the transfer protocol.
   int          m_state = S_IDLE;
   int          m_wait  = 0;
   logic [1:0]  m_wid   = '0;
   logic [2:0]  m_tid   = '0;
   logic [31:0] m_isr   = '0;
   logic [31:0] m_spc   = '0;
   logic [5:0]  m_stm   = '0;
   logic [2:0]  m_swm   = '0;
   logic        m_rv    = 1'b0;
   logic [1:0]  m_rs    = '0;
   logic [31:0] m_rpc   = '0;

   always @(posedge clk) begin : model
      logic fire;
      if (rst) begin
         m_state = S_IDLE; m_wait = 0; m_wid = '0; m_tid = '0; m_isr = '0;
         m_spc = '0; m_stm = '0; m_swm = '0; m_rv = 1'b0; m_rs = '0; m_rpc = '0;
      end else begin
         fire = irq_valid && (m_state == S_IDLE) && !m_rv;
         if (m_rv && resp_ready) m_rv = 1'b0;
         case (m_state)
            S_IDLE: if (fire) begin
               m_wid = irq_wid; m_tid = irq_tid; m_isr = irq_isr_pc;
               if (int'(irq_tid) >= THREAD_CNT || int'(irq_wid) >= WARP_CNT) begin
                  m_rv = 1'b1; m_rs = 2'd3; m_rpc = '0;
               end else begin
                  m_state = S_WAIT; m_wait = 0;
               end
            end
            S_WAIT: begin
               m_wait = m_wait + 1;
               if (u_if.pipeline_drained) begin
                  if (u_if.thread_found) begin
                     m_spc = u_if.current_pc; m_stm = u_if.current_thread_mask;
                     m_swm = u_if.current_active_warps; m_state = S_PC_SWAP;
                  end else begin
                     m_state = S_IDLE; m_rv = 1'b1; m_rs = 2'd1; m_rpc = '0;
                  end
               end else if (TO_EN && m_wait >= TIMEOUT_CYCLES) begin
                  m_state = S_IDLE; m_rv = 1'b1; m_rs = 2'd2; m_rpc = '0;
               end
            end
            S_PC_SWAP: m_state = S_WAIT_ISR;
            S_WAIT_ISR: if (u_if.isr_done) m_state = S_REVERT;
            S_REVERT: begin
               m_state = S_IDLE; m_rv = 1'b1; m_rs = 2'd0; m_rpc = m_spc;
            end
            default: m_state = S_IDLE;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_cycle();
      logic [31:0] e_pc;
      e_pc = (m_state == S_PC_SWAP || m_state == S_WAIT_ISR) ? m_isr :
             (m_state == S_REVERT) ? m_spc : 32'd0;
      chk("irq_ready", 64'(irq_ready), 64'(m_state == S_IDLE && !m_rv));
      chk("ttu_state", 64'(u_if.state), 64'(m_state));
      chk("ttu_wid", 64'(u_if.wid), 64'(m_wid));
      chk("ttu_tid", 64'(u_if.tid), 64'(m_tid));
      chk("load_pc", 64'(u_if.load_pc), 64'(e_pc));
      chk("load_tmask", 64'(u_if.load_tmask), 64'((m_state == S_REVERT) ? m_stm : 6'd0));
      chk("load_wmask", 64'(u_if.load_wmask), 64'((m_state == S_REVERT) ? m_swm : 3'd0));
      chk("rha", 64'(u_if.rha), 64'(rha_addr));
      chk("resp_valid", 64'(resp_valid), 64'(m_rv));
      if (m_rv) begin
         chk("resp_status", 64'(resp_status), 64'(m_rs));
         chk("resp_pc", 64'(resp_pc), 64'(m_rpc));
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         check_cycle();
      end
   endtask

   task automatic send_req(input logic [1:0] w, input logic [2:0] t, input logic [31:0] pc,
                           output int waited);
      irq_valid = 1'b1; irq_wid = w; irq_tid = t; irq_isr_pc = pc;
      waited = 0;
      while (!irq_ready && waited < 50) begin
         tick(1);
         waited++;
      end
      if (!irq_ready) chk("req_accept_timeout", 64'(irq_ready), 64'd1);
      tick(1);
      irq_valid = 1'b0;
   endtask

   task automatic consume();
      resp_ready = 1'b1;
      tick(1);
      resp_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w;
      rst = 1'b1; irq_valid = 1'b0; irq_wid = '0; irq_tid = '0; irq_isr_pc = '0;
      rha_addr = 32'hC000_0000; resp_ready = 1'b0;
      u_if.pipeline_drained = 1'b0; u_if.thread_found = 1'b0;
      u_if.current_thread_mask = '0; u_if.current_pc = '0;
      u_if.current_active_warps = '0; u_if.isr_done = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
      chk("rst state", 64'(u_if.state), 64'(S_IDLE));
      chk("rst resp_valid", 64'(resp_valid), 64'd0);
      chk("rst resp_status", 64'(resp_status), 64'd0);
      chk("rst resp_pc", 64'(resp_pc), 64'd0);
      chk("rst irq_ready", 64'(irq_ready), 64'd1);
      chk("rst load_pc", 64'(u_if.load_pc), 64'd0);

      // Nominal transfer
      send_req(2'd1, 3'd3, 32'h8000_0100, w);
      chk("t1 wait", 64'(u_if.state), 64'(S_WAIT));
      tick(4);
      u_if.pipeline_drained = 1'b1; u_if.thread_found = 1'b1;
      u_if.current_pc = 32'h8000_0040; u_if.current_thread_mask = 6'hF;
      u_if.current_active_warps = 3'h3;
      tick(1);
      u_if.pipeline_drained = 1'b0; u_if.current_pc = 32'hDEAD_BEEF;
      u_if.current_thread_mask = 6'h3F; u_if.current_active_warps = 3'h7;
      chk("t1 swap state", 64'(u_if.state), 64'(S_PC_SWAP));
      chk("t1 swap load_pc", 64'(u_if.load_pc), 64'h8000_0100);
      tick(1);
      chk("t1 isr state", 64'(u_if.state), 64'(S_WAIT_ISR));
      chk("t1 isr load_pc", 64'(u_if.load_pc), 64'h8000_0100);
      tick(19);
      u_if.isr_done = 1'b1;
      tick(1);
      u_if.isr_done = 1'b0;
      chk("t1 revert state", 64'(u_if.state), 64'(S_REVERT));
      chk("t1 revert load_pc", 64'(u_if.load_pc), 64'h8000_0040);
      chk("t1 revert tmask", 64'(u_if.load_tmask), 64'hF);
      chk("t1 revert wmask", 64'(u_if.load_wmask), 64'h3);
      tick(1);
      chk("t1 done state", 64'(u_if.state), 64'(S_IDLE));
      chk("t1 resp_valid", 64'(resp_valid), 64'd1);
      chk("t1 status", 64'(resp_status), 64'd0);
      chk("t1 resp_pc", 64'(resp_pc), 64'h8000_0040);
      consume();

      // Thread not found
      send_req(2'd0, 3'd1, 32'h0000_1234, w);
      tick(2);
      u_if.pipeline_drained = 1'b1; u_if.thread_found = 1'b0;
      tick(1);
      u_if.pipeline_drained = 1'b0;
      chk("t2 state", 64'(u_if.state), 64'(S_IDLE));
      chk("t2 status", 64'(resp_status), 64'd1);
      chk("t2 resp_pc", 64'(resp_pc), 64'd0);
      consume();

      // Bad thread id
      send_req(2'd2, 3'(THREAD_CNT), 32'h0000_5678, w);
      chk("t3 state", 64'(u_if.state), 64'(S_IDLE));
      chk("t3 resp_valid", 64'(resp_valid), 64'd1);
      chk("t3 status", 64'(resp_status), 64'd3);
      chk("t3 irq_ready", 64'(irq_ready), 64'd0);
      consume();

      // Backpressure on a bad-warp response, then back-to-back request
      send_req(2'(WARP_CNT), 3'd0, 32'h0000_9ABC, w);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("t4 held status", 64'(resp_status), 64'd3);
         chk("t4 held ready", 64'(irq_ready), 64'd0);
      end
      consume();
      chk("t4 ready after accept", 64'(irq_ready), 64'd1);
      send_req(2'd1, 3'd2, 32'h0000_4000, w);
      chk("t4 b2b no wait", 64'(w), 64'd0);
      chk("t4 b2b state", 64'(u_if.state), 64'(S_WAIT));
      u_if.pipeline_drained = 1'b1; u_if.thread_found = 1'b0;
      tick(1);
      u_if.pipeline_drained = 1'b0;
      consume();

      // Never drained
      send_req(2'd0, 3'd0, 32'h0000_7000, w);
`ifdef IRQC_TIMEOUT_EN
      tick(TIMEOUT_CYCLES - 1);
      chk("t5 still waiting", 64'(u_if.state), 64'(S_WAIT));
      tick(1);
      chk("t5 timeout state", 64'(u_if.state), 64'(S_IDLE));
      chk("t5 timeout status", 64'(resp_status), 64'd2);
`else
      tick(1000);
      chk("t5 still waiting", 64'(u_if.state), 64'(S_WAIT));
      chk("t5 no resp", 64'(resp_valid), 64'd0);
      u_if.pipeline_drained = 1'b1; u_if.thread_found = 1'b0;
      tick(1);
      u_if.pipeline_drained = 1'b0;
`endif
      consume();

      // Reset while waiting for ISR completion
      send_req(2'd2, 3'd5, 32'h0000_8800, w);
      u_if.pipeline_drained = 1'b1; u_if.thread_found = 1'b1;
      u_if.current_pc = 32'h0000_0200; u_if.current_thread_mask = 6'h21;
      u_if.current_active_warps = 3'h5;
      tick(1);
      u_if.pipeline_drained = 1'b0;
      tick(3);
      chk("t6 pre state", 64'(u_if.state), 64'(S_WAIT_ISR));
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t6 state", 64'(u_if.state), 64'(S_IDLE));
      chk("t6 resp_valid", 64'(resp_valid), 64'd0);
      chk("t6 load_pc", 64'(u_if.load_pc), 64'd0);
      chk("t6 load_tmask", 64'(u_if.load_tmask), 64'd0);
      chk("t6 irq_ready", 64'(irq_ready), 64'd1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         irq_valid  = ($urandom_range(0, 3) == 0);
         irq_wid    = 2'($urandom_range(0, WARP_CNT));
         irq_tid    = 3'($urandom_range(0, THREAD_CNT));
         irq_isr_pc = $urandom;
         if ($urandom_range(0, 63) == 0) rha_addr = $urandom;
         u_if.pipeline_drained     = ($urandom_range(0, 3) == 0);
         u_if.thread_found         = 1'($urandom_range(0, 1));
         u_if.current_pc           = $urandom;
         u_if.current_thread_mask  = 6'($urandom);
         u_if.current_active_warps = 3'($urandom);
         u_if.isr_done             = ($urandom_range(0, 7) == 0);
         resp_ready                = 1'($urandom_range(0, 1));
         rst                       = ($urandom_range(0, 499) == 0);
         tick(1);
      end
      rst = 1'b0; irq_valid = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
